// File: rtl/btn_conditioner.sv
// Push-button front end: synchronises, debounces and edge-detects four buttons, and adds
// hold-to-repeat on Up/Down. All outputs are registered.
module btn_conditioner #(
    parameter bit          ACTIVE_LOW        = 1'b1,
    parameter int unsigned DB_CYCLES         = 1_000_000,
    parameter int unsigned RPT_DELAY_CYCLES  = 25_000_000,
    parameter int unsigned RPT_PERIOD_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up_raw,
    input  logic       down_raw,
    input  logic       mode_raw,
    input  logic       sel_raw,
    output logic       up_pulse,
    output logic       down_pulse,
    output logic       mode_pulse,
    output logic       sel_pulse,
    output logic [3:0] btn_level
);

    localparam int unsigned DbW    = $clog2(DB_CYCLES + 1);
    localparam int unsigned RptMax = (RPT_DELAY_CYCLES > RPT_PERIOD_CYCLES) ?
                                     RPT_DELAY_CYCLES : RPT_PERIOD_CYCLES;
    localparam int unsigned RptW   = $clog2(RptMax + 1);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rpt_state_e;

    logic [3:0]     raw;
    logic [3:0]     sync1_q, sync2_q;
    logic [3:0]     pressed;
    logic [3:0]     level_d, level_q;
    logic [3:0]     prev_q;
    logic [3:0]     rise;
    logic [DbW-1:0] db_cnt_d [4];
    logic [DbW-1:0] db_cnt_q [4];

    rpt_state_e      state_d [2];
    rpt_state_e      state_q [2];
    logic [RptW-1:0] rpt_cnt_d [2];
    logic [RptW-1:0] rpt_cnt_q [2];
    logic [1:0]      fire;
    logic            both_held;

    logic [3:0] pulse_d, pulse_q;
    logic [3:0] btn_level_q;

    // Bit order {sel, mode, down, up} is used for every 4-bit vector below.
    assign raw     = {sel_raw, mode_raw, down_raw, up_raw};
    assign pressed = sync2_q ^ {4{ACTIVE_LOW}};
    assign rise    = level_q & ~prev_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            level_d[i]  = level_q[i];
            db_cnt_d[i] = '0;
            if (pressed[i] != level_q[i]) begin
                if (db_cnt_q[i] == DbW'(DB_CYCLES - 1)) begin
                    level_d[i] = pressed[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Holding both Up and Down parks both repeaters; only a fresh press re-arms them.
    assign both_held = level_q[0] & level_q[1];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i]   = state_q[i];
            rpt_cnt_d[i] = rpt_cnt_q[i];
            fire[i]      = 1'b0;
            if (!level_q[i] || both_held) begin
                state_d[i]   = StIdle;
                rpt_cnt_d[i] = '0;
            end else begin
                case (state_q[i])
                    StIdle: begin
                        if (rise[i]) begin
                            state_d[i]   = StDelay;
                            rpt_cnt_d[i] = '0;
                        end
                    end
                    StDelay: begin
                        if (rpt_cnt_q[i] == RptW'(RPT_DELAY_CYCLES - 1)) begin
                            fire[i]      = 1'b1;
                            state_d[i]   = StRepeat;
                            rpt_cnt_d[i] = '0;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                        end
                    end
                    StRepeat: begin
                        if (rpt_cnt_q[i] == RptW'(RPT_PERIOD_CYCLES - 1)) begin
                            fire[i]      = 1'b1;
                            rpt_cnt_d[i] = '0;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[i]   = StIdle;
                        rpt_cnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    assign pulse_d = rise | {2'b00, fire};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= {4{ACTIVE_LOW}};
            sync2_q     <= {4{ACTIVE_LOW}};
            level_q     <= '0;
            prev_q      <= '0;
            pulse_q     <= '0;
            btn_level_q <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                state_q[i]   <= StIdle;
                rpt_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            prev_q      <= level_q;
            pulse_q     <= pulse_d;
            btn_level_q <= level_q;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            for (int i = 0; i < 2; i++) begin
                state_q[i]   <= state_d[i];
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
        end
    end

    assign up_pulse   = pulse_q[0];
    assign down_pulse = pulse_q[1];
    assign mode_pulse = pulse_q[2];
    assign sel_pulse  = pulse_q[3];
    assign btn_level  = btn_level_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: expected pulses are queued with their due cycle when
// stimulus is applied and compared as the cycles elapse.
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up_raw = 1'b0, down_raw = 1'b0, mode_raw = 1'b0, sel_raw = 1'b0;
    logic       up_pulse, down_pulse, mode_pulse, sel_pulse;
    logic [3:0] btn_level;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  pulses;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc    = 0;
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    btn_conditioner #(
        .ACTIVE_LOW       (1'b0),
        .DB_CYCLES        (4),
        .RPT_DELAY_CYCLES (20),
        .RPT_PERIOD_CYCLES(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .up_raw    (up_raw),
        .down_raw  (down_raw),
        .mode_raw  (mode_raw),
        .sel_raw   (sel_raw),
        .up_pulse  (up_pulse),
        .down_pulse(down_pulse),
        .mode_pulse(mode_pulse),
        .sel_pulse (sel_pulse),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int unsigned at, input logic [3:0] p);
        exp_t e;
        e.cyc    = at;
        e.pulses = p;
        exp_q.push_back(e);
    endtask

    // One clock, then compare pulses whenever one is due or one appears.
    task automatic step();
        logic [3:0] obs;
        logic [3:0] exp;
        bit         due;
        exp_t       e;
        @(posedge clk);
        #1;
        cyc++;
        obs = {sel_pulse, mode_pulse, down_pulse, up_pulse};
        exp = 4'b0000;
        due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        if (due) begin
            e   = exp_q.pop_front();
            exp = e.pulses;
        end
        if (due || obs != 4'b0000) check("pulse", obs, exp);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        int unsigned c;
        int unsigned p;
        int unsigned r;

        // Reset state
        rst = 1'b1;
        run(3);
        check("reset_level", btn_level, 4'b0000);
        check("reset_pulse", {sel_pulse, mode_pulse, down_pulse, up_pulse}, 4'b0000);
        rst = 1'b0;
        run(2);

        // Bouncing Up, then a clean hold: one pulse 7 edges later
        for (int k = 0; k < 12; k++) begin
            up_raw = ((k % 4) < 2);
            step();
        end
        check("bounce_level", btn_level, 4'b0000);
        up_raw = 1'b1;
        c = cyc;
        push(c + 7, 4'b0001);
        run(7);
        check("bounce_hold_level", btn_level, 4'b0001);
        run(3);
        up_raw = 1'b0;
        run(15);
        check("bounce_release_level", btn_level, 4'b0000);

        // Up held long enough to auto-repeat
        up_raw = 1'b1;
        c = cyc;
        p = c + 7;
        push(p, 4'b0001);
        push(p + 20, 4'b0001);
        push(p + 28, 4'b0001);
        push(p + 36, 4'b0001);
        push(p + 44, 4'b0001);
        push(p + 52, 4'b0001);
        run(60);
        check("repeat_hold_level", btn_level, 4'b0001);
        up_raw = 1'b0;
        run(30);
        check("repeat_release_level", btn_level, 4'b0000);

        // Mode never repeats; a 3-cycle Select glitch is ignored
        mode_raw = 1'b1;
        c = cyc;
        push(c + 7, 4'b0100);
        run(10);
        check("mode_level", btn_level, 4'b0100);
        run(90);
        mode_raw = 1'b0;
        run(10);
        sel_raw = 1'b1;
        run(3);
        sel_raw = 1'b0;
        run(6);
        check("sel_glitch_level", btn_level, 4'b0000);
        run(6);

        // Up and Down together: single presses, no repeats
        up_raw   = 1'b1;
        down_raw = 1'b1;
        c = cyc;
        push(c + 7, 4'b0011);
        run(10);
        check("pair_level", btn_level, 4'b0011);
        run(70);
        up_raw   = 1'b0;
        down_raw = 1'b0;
        run(20);
        check("pair_release_level", btn_level, 4'b0000);

        // Reset while Down is repeating, Down still held afterwards
        down_raw = 1'b1;
        c = cyc;
        push(c + 7, 4'b0010);
        push(c + 27, 4'b0010);
        run(30);
        rst = 1'b1;
        step();
        check("midhold_reset_pulse", {sel_pulse, mode_pulse, down_pulse, up_pulse}, 4'b0000);
        check("midhold_reset_level", btn_level, 4'b0000);
        rst = 1'b0;
        r = cyc;
        push(r + 7, 4'b0010);
        push(r + 27, 4'b0010);
        run(7);
        check("post_reset_level", btn_level, 4'b0010);
        run(21);
        down_raw = 1'b0;
        run(20);
        check("post_reset_release_level", btn_level, 4'b0000);

        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
